// File: rtl/mem_access_arbiter_pkg.sv
// Shared types and line geometry for the memory access arbiter and both cache miss handlers.
package mem_access_arbiter_pkg;

  localparam int unsigned ARB_ADDR_WIDTH = 16;
  localparam int unsigned ARB_DATA_WIDTH = 32;
  localparam int unsigned ARB_LINE_WORDS = 4;

  typedef enum logic {
    OWNER_IC = 1'b0,
    OWNER_DC = 1'b1
  } arb_owner_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ADDR,
    ARB_RDATA,
    ARB_WDATA
  } arb_state_t;

endpackage

// File: rtl/mem_access_arbiter_if.sv
// Cache-side and memory-side handshake bundle; master is the arbiter, slave is the environment.
interface mem_access_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  ic_req;
  logic [ADDR_WIDTH-1:0] ic_addr;
  logic                  ic_gnt;
  logic                  ic_rvalid;
  logic                  ic_done;

  logic                  dc_req;
  logic                  dc_we;
  logic [ADDR_WIDTH-1:0] dc_addr;
  logic [DATA_WIDTH-1:0] dc_wdata;
  logic                  dc_gnt;
  logic                  dc_wnext;
  logic                  dc_rvalid;
  logic                  dc_done;

  logic [DATA_WIDTH-1:0] rdata;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ready;
  logic                  mem_wvalid;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_wready;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    input  ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata,
    input  mem_ready, mem_wready, mem_rvalid, mem_rdata,
    output ic_gnt, ic_rvalid, ic_done,
    output dc_gnt, dc_wnext, dc_rvalid, dc_done, rdata,
    output mem_req, mem_we, mem_addr, mem_wvalid, mem_wdata
  );

  modport slave (
    output ic_req, ic_addr, dc_req, dc_we, dc_addr, dc_wdata,
    output mem_ready, mem_wready, mem_rvalid, mem_rdata,
    input  ic_gnt, ic_rvalid, ic_done,
    input  dc_gnt, dc_wnext, dc_rvalid, dc_done, rdata,
    input  mem_req, mem_we, mem_addr, mem_wvalid, mem_wdata
  );
endinterface

// File: rtl/mem_access_arbiter_rr_arbiter2.sv
// Two-input round-robin picker: on a tie, the requester not served last time wins.
module rr_arbiter2
  import mem_access_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  arb_owner_t last_owner,
  output arb_owner_t winner,
  output logic       valid
);

  always_comb begin
    valid  = |req;
    winner = OWNER_IC;
    case (req)
      2'b01:   winner = OWNER_IC;
      2'b10:   winner = OWNER_DC;
      2'b11:   winner = (last_owner == OWNER_IC) ? OWNER_DC : OWNER_IC;
      default: winner = OWNER_IC;
    endcase
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares the external memory port between i-cache refills and d-cache refills/write-backs,
// one whole line transaction at a time.
module mem_access_arbiter
  import mem_access_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ARB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = ARB_DATA_WIDTH,
  parameter int unsigned LINE_WORDS = ARB_LINE_WORDS
) (
  input logic                 clk,
  input logic                 rst_n,
  mem_access_arbiter_if.master bus
);

  localparam int unsigned     CNT_W     = $clog2(LINE_WORDS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(LINE_WORDS - 1);

  arb_state_t            state_q, state_d;
  arb_owner_t            owner_q, last_owner_q, pick;
  logic                  pick_valid;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [CNT_W-1:0]      beat_q;
  logic                  rd_beat, wr_beat, last_beat;

  rr_arbiter2 u_rr (
    .req        ({bus.dc_req, bus.ic_req}),
    .last_owner (last_owner_q),
    .winner     (pick),
    .valid      (pick_valid)
  );

  // Handshakes only count inside their own data phase; strays elsewhere are ignored.
  assign rd_beat   = (state_q == ARB_RDATA) && bus.mem_rvalid;
  assign wr_beat   = (state_q == ARB_WDATA) && bus.mem_wready;
  assign last_beat = (rd_beat || wr_beat) && (beat_q == LAST_BEAT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ARB_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:  if (pick_valid)    state_d = ARB_ADDR;
      ARB_ADDR:  if (bus.mem_ready) state_d = we_q ? ARB_WDATA : ARB_RDATA;
      ARB_RDATA: if (last_beat)     state_d = ARB_IDLE;
      ARB_WDATA: if (last_beat)     state_d = ARB_IDLE;
      default:                      state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q      <= OWNER_IC;
      last_owner_q <= OWNER_IC;
      addr_q       <= '0;
      we_q         <= 1'b0;
      beat_q       <= '0;
    end else begin
      if (state_q == ARB_IDLE && pick_valid) begin
        owner_q <= pick;
        addr_q  <= (pick == OWNER_DC) ? bus.dc_addr : bus.ic_addr;
        we_q    <= (pick == OWNER_DC) && bus.dc_we;
      end
      if (rd_beat || wr_beat) beat_q <= beat_q + 1'b1;
      if (last_beat)          last_owner_q <= owner_q;
    end
  end

  always_comb begin
    bus.ic_gnt     = 1'b0;
    bus.ic_rvalid  = 1'b0;
    bus.ic_done    = 1'b0;
    bus.dc_gnt     = 1'b0;
    bus.dc_wnext   = 1'b0;
    bus.dc_rvalid  = 1'b0;
    bus.dc_done    = 1'b0;
    bus.rdata      = bus.mem_rdata;
    bus.mem_req    = (state_q == ARB_ADDR);
    bus.mem_we     = (state_q == ARB_ADDR) && we_q;
    bus.mem_addr   = addr_q;
    bus.mem_wvalid = (state_q == ARB_WDATA);
    bus.mem_wdata  = (state_q == ARB_WDATA) ? bus.dc_wdata : '0;
    if (owner_q == OWNER_DC) begin
      bus.dc_gnt    = (state_q == ARB_ADDR) && bus.mem_ready;
      bus.dc_rvalid = rd_beat;
      bus.dc_wnext  = wr_beat;
      bus.dc_done   = last_beat;
    end else begin
      bus.ic_gnt    = (state_q == ARB_ADDR) && bus.mem_ready;
      bus.ic_rvalid = rd_beat;
      bus.ic_done   = last_beat;
    end
  end

endmodule

// File: doc/mem_access_arbiter.md
# mem_access_arbiter

Sequences the single external memory port between the i-cache (line refill reads) and the d-cache (line refill reads and line write-backs). It sits between both caches' miss handlers and the memory interface, granting one whole line transaction at a time with two-way round-robin. It tracks the transaction's address phase and data phase, counts data beats, and routes read data and handshake pulses back to the owning cache.

## Interface
Parameters:
- ADDR_WIDTH, default `ADDR_WIDTH` (16): word address width.
- DATA_WIDTH, default 32: data beat width.
- LINE_WORDS, default 4: beats per transaction; power of two, at least 2.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ic_req  in  1  i-cache line read request; held until ic_gnt.
- ic_addr  in  ADDR_WIDTH  i-cache line base address.
- ic_gnt  out  1  1-cycle pulse: memory accepted the i-cache address.
- ic_rvalid  out  1  read beat valid for the i-cache.
- ic_done  out  1  1-cycle pulse on the last i-cache beat.
- dc_req  in  1  d-cache request; held until dc_gnt.
- dc_we  in  1  1 = write-back, 0 = refill read.
- dc_addr  in  ADDR_WIDTH  d-cache line base address.
- dc_wdata  in  DATA_WIDTH  current write-back beat.
- dc_gnt  out  1  1-cycle pulse: memory accepted the d-cache address.
- dc_wnext  out  1  1-cycle pulse: dc_wdata beat consumed; advance to the next beat.
- dc_rvalid  out  1  read beat valid for the d-cache.
- dc_done  out  1  1-cycle pulse on the last d-cache beat.
- rdata  out  DATA_WIDTH  mem_rdata broadcast to both caches.
- mem_req, mem_we, mem_addr  out  1/1/ADDR_WIDTH  address phase.
- mem_ready  in  1  address accepted this cycle.
- mem_wvalid, mem_wdata  out  1/DATA_WIDTH  write beat.
- mem_wready  in  1  write beat accepted this cycle.
- mem_rvalid, mem_rdata  in  1/DATA_WIDTH  read beat.

## Operation
States:
- IDLE: sample requests. If any request is pending, latch owner, addr and we, then go to ADDR.
- ADDR: drive mem_req=1 with the latched mem_addr and mem_we. When mem_ready is seen, pulse the owner's gnt and go to RDATA if we=0, or WDATA if we=1.
- RDATA: each mem_rvalid raises the owner's rvalid in the same cycle and increments beat_cnt. On the beat where beat_cnt == LINE_WORDS-1, pulse the owner's done, clear beat_cnt and go to IDLE.
- WDATA: drive mem_wvalid=1 with mem_wdata = dc_wdata (combinational). dc_wnext = mem_wready. beat_cnt and exit follow the RDATA rules.

Arbitration and routing:
- Arbitration happens in IDLE only. With a single requester, that requester wins. If both request, the one not granted last time wins.
- last_owner updates when a transaction completes. Its reset value is IC, so the DC wins the first tie.
- ic_we is implicitly 0; the i-cache never enters WDATA.
- beat_cnt is $clog2(LINE_WORDS) bits and wraps naturally to 0 after the last beat.
- mem_rvalid outside RDATA, and mem_wready outside WDATA, are ignored and do not affect the counter.
- The non-owner's gnt, rvalid, wnext and done stay 0 at all times.

## Timing
- Reset (asynchronous, any state, mid-transaction included) forces:
  - state=IDLE, beat_cnt=0, last_owner=IC;
  - mem_req, mem_we, mem_wvalid all 0, mem_addr=0;
  - all gnt, rvalid, wnext and done outputs 0.
  - Any in-flight transaction is abandoned.
- mem_req, mem_addr and mem_we are registered and first asserted in the cycle after the request is seen in IDLE.
- gnt, rvalid, wnext and done are combinational from the memory handshakes in the current state.
- Requesters drop req no later than the cycle after gnt. A req still high in IDLE is treated as a new transaction.
- Back-to-back transactions: the done cycle is followed by one IDLE cycle, then ADDR. Minimum gap is 1 cycle.
- Minimum read transaction is 2 + LINE_WORDS cycles from req to done, with zero-wait memory (ADDR 1 cycle after IDLE, then mem_ready).

## Structure
- Shared package (alongside mips_core.svh definitions):
  - arb_owner_t enum {OWNER_IC, OWNER_DC};
  - arb_state_t enum {ARB_IDLE, ARB_ADDR, ARB_RDATA, ARB_WDATA};
  - LINE_WORDS constant, shared with both caches.
- One sub-module: rr_arbiter2. It is a pure combinational two-input round-robin picker taking req[1:0] and last_owner and producing the winner. The FSM, latches and counter live in mem_access_arbiter.

## Test plan
- ic_req only, addr 0x0100, mem_ready after 2 cycles, 4 rvalid beats 0xA0..0xA3 → one ic_gnt, ic_rvalid ×4 with matching rdata, ic_done on beat 4, dc_* outputs 0.
- ic_req and dc_req raised together after reset → DC granted first. IC is granted in the second transaction, starting exactly 1 idle cycle after dc_done.
- dc write-back, dc_we=1, addr 0x0200, mem_wready asserted on alternating cycles → mem_wdata tracks dc_wdata, dc_wnext pulses only with mem_wready, dc_done on the 4th accept.
- Both requesters hold req across 3 transactions → grants alternate DC, IC, DC.
- Spurious mem_rvalid during ADDR and IDLE → no rvalid out and beat_cnt unchanged; the following transaction still completes after exactly 4 beats.
- rst_n asserted during beat 2 of RDATA → all outputs 0 immediately. After release, a fresh ic_req completes normally, with a tie resolved to DC.
